// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO feeding the UART transmitter.
// Optional sticky drop flag: define UART_TX_FIFO_OVERFLOW_EN.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               wr_data,
    input  logic                     wr_en,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
`ifdef UART_TX_FIFO_OVERFLOW_EN
    output logic                     overflow,
    input  logic                     overflow_clr,
`endif
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;
    localparam int AN = DEPTH - 1;

    logic [7:0]    mem [AN];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] arr_cnt;

    logic          wr_acc;
    logic          pop;
    logic          arr_empty;
    logic          bypass;
    logic          arr_pop;
    logic          arr_push;
    logic          valid_nxt;
    logic [7:0]    data_nxt;
    logic [CW-1:0] count_nxt;
    logic [CW-1:0] arr_cnt_nxt;
    logic [AW-1:0] wr_ptr_nxt;
    logic [AW-1:0] rd_ptr_nxt;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 2)) begin
            return '0;
        end
        return p + AW'(1);
    endfunction

    always_comb begin
        wr_acc    = wr_en && !full;
        pop       = tx_valid && tx_ready;
        arr_empty = (arr_cnt == '0);
        // Output stage takes the write directly when nothing queued ahead of it
        bypass    = wr_acc && (!tx_valid || (pop && arr_empty));
        arr_pop   = pop && !arr_empty;
        arr_push  = wr_acc && !bypass;
    end

    always_comb begin
        valid_nxt   = tx_valid;
        data_nxt    = tx_data;
        wr_ptr_nxt  = wr_ptr;
        rd_ptr_nxt  = rd_ptr;
        count_nxt   = count + CW'(wr_acc) - CW'(pop);
        arr_cnt_nxt = arr_cnt + CW'(arr_push) - CW'(arr_pop);
        if (bypass) begin
            valid_nxt = 1'b1;
            data_nxt  = wr_data;
        end else if (arr_pop) begin
            valid_nxt = 1'b1;
            data_nxt  = mem[rd_ptr];
        end else if (pop) begin
            valid_nxt = 1'b0;
        end
        if (arr_pop) begin
            rd_ptr_nxt = ptr_inc(rd_ptr);
        end
        if (arr_push) begin
            wr_ptr_nxt = ptr_inc(wr_ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (arr_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            arr_cnt  <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            tx_valid <= valid_nxt;
            tx_data  <= data_nxt;
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            arr_cnt  <= arr_cnt_nxt;
            count    <= count_nxt;
            full     <= (count_nxt == CW'(DEPTH));
            empty    <= (count_nxt == '0);
        end
    end

`ifdef UART_TX_FIFO_OVERFLOW_EN
    // Set has priority over clear so a drop is never lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO that sits directly upstream of the UART transmitter and decouples bursty byte producers from the serial line. Producers write bytes at any rate up to one per clock. The FIFO presents them in order on a valid/ready port that connects straight to the transmitter's `data`/`valid`/`ready` inputs. Each byte is held stable until the transmitter accepts it.

## Interface
- `DEPTH`, 16: total byte capacity, including the output register. Must be a power of 2 and ≥ 2.
- `clk` input 1: system clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `wr_data` input 8: byte to enqueue.
- `wr_en` input 1: enqueue request, sampled every cycle.
- `full` output 1: high when `count == DEPTH`.
- `empty` output 1: high when `count == 0`.
- `count` output $clog2(DEPTH)+1: bytes currently held, including the output register.
- `tx_data` output 8: head byte; connects to the transmitter's `data`.
- `tx_valid` output 1: head byte present; connects to the transmitter's `valid`.
- `tx_ready` input 1: connects to the transmitter's `ready`.
- `overflow` output 1: sticky drop flag (present only with the macro, see Configuration).
- `overflow_clr` input 1: clears `overflow` (present only with the macro).

## Operation
- Storage: a circular array of DEPTH-1 entries plus one registered output stage (`tx_data`/`tx_valid`), organised first-word-fall-through.
- Write accept: `wr_en && !full`.
  - `full` is the registered value.
  - A write while full is dropped, even if a pop happens in the same cycle.
- Pop: `tx_valid && tx_ready`. The output stage then reloads from the array head, or goes invalid if the array is empty.
- Ordering: strict FIFO; no byte is duplicated or reordered.
- Pointers: read and write pointers are $clog2(DEPTH-1)-bit indices that wrap from DEPTH-2 to 0. Full/empty is derived from `count`, not from pointer equality.
- Count update:
  - +1 on write accept only.
  - −1 on pop only.
  - Unchanged when both happen in the same cycle.
- Bypass: a write accepted while the output stage is empty, or is being popped with an empty array, loads the output stage directly.
- Simultaneous write and pop at `count==1`: the new byte appears on `tx_data` next cycle; `count` stays 1.
- `tx_data` must not change while `tx_valid && !tx_ready`.
- Reset mid-operation: all contents are discarded immediately; no partial byte is presented afterwards.

## Timing
- Reset values:
  - `tx_valid=0`, `tx_data=8'h00`, `count=0`, `empty=1`, `full=0`, `overflow=0`.
  - Pointers are 0.
- Write-to-valid latency into an empty FIFO: a write accepted on edge N gives `tx_valid=1` with that byte after edge N, i.e. 1 cycle.
- Pop-to-next latency: a pop on edge N presents the next byte after edge N. Back-to-back pops at one per cycle are supported.
- The transmitter lowers `ready` the cycle after it accepts a byte. The FIFO needs no extra gap: `tx_valid` may stay high with the next byte.
- `full`, `empty` and `count` are registered and reflect the state after the edge.

## Configuration
- `UART_TX_FIFO_OVERFLOW_EN` defined:
  - `overflow` and `overflow_clr` exist.
  - `overflow` sets on the edge after any dropped write and stays high until `overflow_clr` is sampled high.
  - If set and clear occur in the same cycle, set wins.
- `UART_TX_FIFO_OVERFLOW_EN` undefined: neither port exists, and dropped writes are silent.

## Test plan
- Reset: with `rst_n=0`, all outputs are at their reset values. Releasing reset with `wr_en=0` gives no change.
- Single byte: write 8'h55 at edge N with `tx_ready=0`. Expect `tx_valid=1` and `tx_data=8'h55` from N+1, held 10 cycles. Raise `tx_ready` for 1 cycle: `tx_valid=0` and `count=0` next cycle.
- Fill and overflow (DEPTH=16): write 8'h00..8'h0F with `tx_ready=0`, giving `full=1` and `count=16`. Write 8'hAA: dropped, `count=16`, and `overflow=1` with the macro. Drain: 8'h00..8'h0F in order, with no 8'hAA.
- Wrap-around: 40 bytes 8'h00..8'h27 written and drained continuously with `tx_ready` toggling at random. Output matches the input sequence exactly; `count` never exceeds 16.
- Simultaneous write and pop at `count==1` (head 8'h11, write 8'h22, `tx_ready=1`): next cycle `tx_data=8'h22`, `tx_valid=1`, `count=1`.
- Reset mid-stream: with `count=5`, assert `rst_n=0` asynchronously between edges. Outputs go to reset values immediately. After release, the first write, 8'h7E, is the first byte presented.
